// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM that sequences the shared-memory
// datapath one step per clock and counts retired instructions.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic [5:0]       opcode_i,
    input  logic [5:0]       funct_i,
    input  logic             zero_i,
    output logic             pc_en_o,
    output logic             ir_en_o,
    output logic             mem_we_o,
    output logic             rf_we_o,
    output logic             iord_o,
    output logic [1:0]       a3_sel_o,
    output logic [1:0]       wd_sel_o,
    output logic             alu_a_sel_o,
    output logic [1:0]       alu_b_sel_o,
    output logic [1:0]       ext_op_o,
    output logic [2:0]       alu_op_o,
    output logic [1:0]       pc_sel_o,
    output logic [3:0]       state_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMRD    = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWR    = 4'd5;
    localparam logic [3:0] RTYPE_EX = 4'd6;
    localparam logic [3:0] ALUWB    = 4'd7;
    localparam logic [3:0] BEQ      = 4'd8;
    localparam logic [3:0] IMM_EX   = 4'd9;
    localparam logic [3:0] IMMWB    = 4'd10;
    localparam logic [3:0] JUMP     = 4'd11;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LUI = 6'b001111;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    localparam logic [5:0] FN_NOP  = 6'b000000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;

    logic       isR, isRAlu, isJr, isNop;
    logic       pcEn, irEn, memWe, rfWe, iord, aluASel, illegal;
    logic [1:0] a3Sel, wdSel, aluBSel, extOp, pcSel;
    logic [2:0] aluOp;

    assign isR    = (opcode_i == OP_R);
    assign isRAlu = isR && ((funct_i == FN_ADDU) || (funct_i == FN_SUBU));
    assign isJr   = isR && (funct_i == FN_JR);
    assign isNop  = isR && (funct_i == FN_NOP);

    always_comb begin
        state_d = FETCH;
        retire  = 1'b0;
        unique case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                if (opcode_i == OP_LW || opcode_i == OP_SW) begin
                    state_d = MEMADR;
                end else if (isRAlu) begin
                    state_d = RTYPE_EX;
                end else if (opcode_i == OP_BEQ) begin
                    state_d = BEQ;
                end else if (opcode_i == OP_ORI || opcode_i == OP_LUI) begin
                    state_d = IMM_EX;
                end else if (opcode_i == OP_J || opcode_i == OP_JAL || isJr) begin
                    state_d = JUMP;
                end else begin
                    state_d = FETCH;
                    retire  = isNop;
                end
            end
            MEMADR:   state_d = (opcode_i == OP_LW) ? MEMRD : MEMWR;
            MEMRD:    state_d = MEMWB;
            RTYPE_EX: state_d = ALUWB;
            IMM_EX:   state_d = IMMWB;
            MEMWB, MEMWR, ALUWB, BEQ, IMMWB, JUMP: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            default:  state_d = FETCH;
        endcase
    end

    assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Moore decode; only BEQ (zero flag) and the data-dependent states look at inputs.
    always_comb begin
        pcEn    = 1'b0;
        irEn    = 1'b0;
        memWe   = 1'b0;
        rfWe    = 1'b0;
        iord    = 1'b0;
        a3Sel   = 2'd0;
        wdSel   = 2'd0;
        aluASel = 1'b0;
        aluBSel = 2'd0;
        extOp   = 2'd0;
        aluOp   = ALU_ADD;
        pcSel   = 2'd0;
        illegal = 1'b0;
        unique case (state_q)
            FETCH: begin
                irEn    = 1'b1;
                aluBSel = 2'd1;
                pcEn    = 1'b1;
            end
            DECODE: begin
                aluBSel = 2'd3;
                extOp   = 2'd1;
                illegal = !(opcode_i == OP_LW || opcode_i == OP_SW || isRAlu ||
                            opcode_i == OP_BEQ || opcode_i == OP_ORI ||
                            opcode_i == OP_LUI || opcode_i == OP_J ||
                            opcode_i == OP_JAL || isJr || isNop);
            end
            MEMADR: begin
                aluASel = 1'b1;
                aluBSel = 2'd2;
                extOp   = 2'd1;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                rfWe  = 1'b1;
                wdSel = 2'd1;
            end
            MEMWR: begin
                iord  = 1'b1;
                memWe = 1'b1;
            end
            RTYPE_EX: begin
                aluASel = 1'b1;
                aluOp   = (funct_i == FN_SUBU) ? ALU_SUB : ALU_ADD;
            end
            ALUWB: begin
                rfWe  = 1'b1;
                a3Sel = 2'd1;
            end
            BEQ: begin
                aluASel = 1'b1;
                aluOp   = ALU_SUB;
                pcSel   = 2'd1;
                pcEn    = zero_i;
            end
            IMM_EX: begin
                aluASel = 1'b1;
                aluBSel = 2'd2;
                aluOp   = ALU_OR;
                extOp   = (opcode_i == OP_LUI) ? 2'd2 : 2'd0;
            end
            IMMWB: rfWe = 1'b1;
            JUMP: begin
                pcEn = 1'b1;
                if (isJr) begin
                    pcSel = 2'd3;
                end else begin
                    pcSel = 2'd2;
                    if (opcode_i == OP_JAL) begin
                        rfWe  = 1'b1;
                        a3Sel = 2'd2;
                        wdSel = 2'd2;
                    end
                end
            end
            default: ;
        endcase
    end

    // Reset forces every strobe and select low even though state already reads FETCH.
    assign pc_en_o     = reset_ni & pcEn;
    assign ir_en_o     = reset_ni & irEn;
    assign mem_we_o    = reset_ni & memWe;
    assign rf_we_o     = reset_ni & rfWe;
    assign iord_o      = reset_ni & iord;
    assign a3_sel_o    = reset_ni ? a3Sel   : 2'd0;
    assign wd_sel_o    = reset_ni ? wdSel   : 2'd0;
    assign alu_a_sel_o = reset_ni & aluASel;
    assign alu_b_sel_o = reset_ni ? aluBSel : 2'd0;
    assign ext_op_o    = reset_ni ? extOp   : 2'd0;
    assign alu_op_o    = reset_ni ? aluOp   : 3'd0;
    assign pc_sel_o    = reset_ni ? pcSel   : 2'd0;
    assign illegal_o   = reset_ni & illegal;
    assign state_o     = state_q;
    assign retired_o   = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class state by state
// and compares the full control bundle against hand-written vectors.
module tb_mc_ctrl;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             resetN = 1'b0;
   logic [5:0]       opcode = '0;
   logic [5:0]       funct = '0;
   logic             zero = 1'b0;
   logic             pcEn, irEn, memWe, rfWe, iord, aluASel, illegal;
   logic [1:0]       a3Sel, wdSel, aluBSel, extOp, pcSel;
   logic [2:0]       aluOp;
   logic [3:0]       state;
   logic [CNT_W-1:0] retired;
   logic [19:0]      ctlBus;

   int compared = 0;
   int mismatched = 0;

   logic [3:0]  seqState[$];
   logic [19:0] seqCtl[$];

   mc_ctrl #(.CNT_W(CNT_W)) dut (
      .clk_i(clk), .reset_ni(resetN), .opcode_i(opcode), .funct_i(funct), .zero_i(zero),
      .pc_en_o(pcEn), .ir_en_o(irEn), .mem_we_o(memWe), .rf_we_o(rfWe), .iord_o(iord),
      .a3_sel_o(a3Sel), .wd_sel_o(wdSel), .alu_a_sel_o(aluASel), .alu_b_sel_o(aluBSel),
      .ext_op_o(extOp), .alu_op_o(aluOp), .pc_sel_o(pcSel), .state_o(state),
      .illegal_o(illegal), .retired_o(retired)
   );

   // Flatten all control outputs so each step is one comparison.
   assign ctlBus = {pcEn, irEn, memWe, rfWe, iord, a3Sel, wdSel, aluASel,
                    aluBSel, extOp, aluOp, pcSel, illegal};

   always #5 clk = ~clk;

   function automatic logic [19:0] ctl(input logic pe, ie, mw, rw, io,
                                       input logic [1:0] a3, wd, input logic aa,
                                       input logic [1:0] ab, ex, input logic [2:0] op,
                                       input logic [1:0] ps, input logic il);
      return {pe, ie, mw, rw, io, a3, wd, aa, ab, ex, op, ps, il};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic expectStep(input logic [3:0] s, input logic [19:0] c);
      seqState.push_back(s);
      seqCtl.push_back(c);
   endtask

   // Entered at a falling edge while in FETCH; leaves at the falling edge of the next FETCH.
   task automatic applyStimulus(input string tag, input logic [5:0] op,
                                input logic [5:0] fn, input logic z);
      opcode = op;
      funct  = fn;
      zero   = z;
      for (int i = 0; i < seqState.size(); i++) begin
         checkOutput($sformatf("%s.state%0d", tag, i), 32'(state), 32'(seqState[i]));
         checkOutput($sformatf("%s.ctl%0d", tag, i), 32'(ctlBus), 32'(seqCtl[i]));
         @(negedge clk);
      end
      seqState.delete();
      seqCtl.delete();
   endtask

   logic [19:0] cFetch, cDecode, cDecIll, cMemAdr, cMemRd, cMemWb, cMemWr;
   logic [19:0] cAddu, cSubu, cAluWb, cBeqT, cBeqF, cOri, cLui, cImmWb, cJal, cJr;

   initial begin
      //              pe ie mw rw io a3 wd aa ab ex op pc il
      cFetch  = ctl(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      cDecode = ctl(0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      cDecIll = ctl(0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 1);
      cMemAdr = ctl(0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0);
      cMemRd  = ctl(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      cMemWb  = ctl(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      cMemWr  = ctl(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      cAddu   = ctl(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      cSubu   = ctl(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
      cAluWb  = ctl(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      cBeqT   = ctl(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
      cBeqF   = ctl(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
      cOri    = ctl(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 2, 0, 0);
      cLui    = ctl(0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 2, 0, 0);
      cImmWb  = ctl(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cJal    = ctl(1, 0, 0, 1, 0, 2, 2, 0, 0, 0, 0, 2, 0);
      cJr     = ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);

      // Reset held low: everything quiet, then release at a falling edge.
      #12;
      checkOutput("rst.state", 32'(state), 32'd0);
      checkOutput("rst.ctl", 32'(ctlBus), 32'd0);
      checkOutput("rst.retired", 32'(retired), 32'd0);
      @(negedge clk);
      resetN = 1'b1;
      #1;

      expectStep(0, cFetch); expectStep(1, cDecode); expectStep(2, cMemAdr);
      expectStep(3, cMemRd); expectStep(4, cMemWb);
      applyStimulus("lw", 6'b100011, 6'd0, 1'b0);
      expectStep(0, cFetch); expectStep(1, cDecode); expectStep(2, cMemAdr);
      expectStep(5, cMemWr);
      applyStimulus("sw", 6'b101011, 6'd0, 1'b0);
      checkOutput("memops.retired", 32'(retired), 32'd2);

      expectStep(0, cFetch); expectStep(1, cDecode); expectStep(8, cBeqT);
      applyStimulus("beqTaken", 6'b000100, 6'd0, 1'b1);
      expectStep(0, cFetch); expectStep(1, cDecode); expectStep(8, cBeqF);
      applyStimulus("beqNot", 6'b000100, 6'd0, 1'b0);
      checkOutput("beq.retired", 32'(retired), 32'd4);

      expectStep(0, cFetch); expectStep(1, cDecode); expectStep(6, cAddu);
      expectStep(7, cAluWb);
      applyStimulus("addu", 6'b000000, 6'b100001, 1'b0);
      expectStep(0, cFetch); expectStep(1, cDecode); expectStep(6, cSubu);
      expectStep(7, cAluWb);
      applyStimulus("subu", 6'b000000, 6'b100011, 1'b0);
      expectStep(0, cFetch); expectStep(1, cDecode); expectStep(9, cOri);
      expectStep(10, cImmWb);
      applyStimulus("ori", 6'b001101, 6'd0, 1'b0);
      expectStep(0, cFetch); expectStep(1, cDecode); expectStep(9, cLui);
      expectStep(10, cImmWb);
      applyStimulus("lui", 6'b001111, 6'd0, 1'b0);
      checkOutput("alu.retired", 32'(retired), 32'd8);

      expectStep(0, cFetch); expectStep(1, cDecode); expectStep(11, cJal);
      applyStimulus("jal", 6'b000011, 6'd0, 1'b0);
      expectStep(0, cFetch); expectStep(1, cDecode); expectStep(11, cJr);
      applyStimulus("jr", 6'b000000, 6'b001000, 1'b0);
      checkOutput("jump.retired", 32'(retired), 32'd10);

      expectStep(0, cFetch); expectStep(1, cDecIll);
      applyStimulus("illegal", 6'b111111, 6'd0, 1'b0);
      checkOutput("illegal.retired", 32'(retired), 32'd10);
      checkOutput("illegal.cleared", 32'(illegal), 32'd0);

      // Abort an addu in RTYPE_EX with an asynchronous reset.
      expectStep(0, cFetch); expectStep(1, cDecode);
      applyStimulus("abort", 6'b000000, 6'b100001, 1'b0);
      checkOutput("abort.inEx", 32'(state), 32'd6);
      #2 resetN = 1'b0;
      #1;
      checkOutput("abort.state", 32'(state), 32'd0);
      checkOutput("abort.ctl", 32'(ctlBus), 32'd0);
      checkOutput("abort.retired", 32'(retired), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("abort.held", 32'(state), 32'd0);
      @(negedge clk);
      resetN = 1'b1;
      #1;
      checkOutput("release.pcIr", 32'({pcEn, irEn}), 32'b11);

      // Sixteen nops wrap the 4-bit counter back to zero.
      for (int n = 0; n < 16; n++) begin
         expectStep(0, cFetch); expectStep(1, cDecode);
         applyStimulus($sformatf("nop%0d", n), 6'b000000, 6'b000000, 1'b0);
         if (n == 14) checkOutput("nop.retired15", 32'(retired), 32'd15);
      end
      checkOutput("nop.wrap", 32'(retired), 32'd0);
      checkOutput("nop.state", 32'(state), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
